// File: rtl/imem_loader_if.sv
// Boot-load bus: byte stream in, instruction-memory write port out, core handoff signals.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic                  cpu_run;
    logic                  busy;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport master (
        output start, len, byte_in, byte_valid, cpu_addr,
        input  byte_ready, mem_addr, mem_wdata, mem_we, cpu_run, busy, error, words_loaded
    );

    modport slave (
        input  start, len, byte_in, byte_valid, cpu_addr,
        output byte_ready, mem_addr, mem_wdata, mem_we, cpu_run, busy, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a big-endian byte stream into 32-bit
// words, writes them from address 0 upward, then releases the core.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_asm;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic                  r_byte_ready;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [LW-1:0]         r_words;
    logic [LW-1:0]         r_acc;
    logic [LW-1:0]         r_len;
    logic [TMO_W-1:0]      r_tmo;

    logic w_len_ok;
    logic w_accept;
    logic w_enter;
    logic w_last_write;
    logic w_timeout;
    logic w_busy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_len_ok     = (bus.len != '0) && (bus.len <= LW'(DEPTH));
        w_accept     = (r_state == S_LOAD) && r_byte_ready && bus.byte_valid;
        w_enter      = (r_state != S_LOAD) && bus.start && w_len_ok;
        w_last_write = r_we && (r_words == (r_len - LW'(1)));
        w_timeout    = !w_accept && (r_tmo == TMO_W'(TIMEOUT - 1));
        case (r_state)
            S_LOAD: begin
                if (w_last_write) begin
                    w_next_state = S_DONE;
                end else if (w_timeout) begin
                    w_next_state = S_ERR;
                end
            end
            default: begin
                if (bus.start) begin
                    w_next_state = w_len_ok ? S_LOAD : S_ERR;
                end
            end
        endcase
    end

    // Byte packing, word write pulse and load counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_byte_ready <= 1'b0;
            r_waddr      <= '0;
            r_words      <= '0;
            r_acc        <= '0;
            r_len        <= '0;
            r_tmo        <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_enter) begin
                r_byte_cnt   <= '0;
                r_waddr      <= '0;
                r_words      <= '0;
                r_acc        <= '0;
                r_tmo        <= '0;
                r_len        <= bus.len;
                r_byte_ready <= 1'b1;
            end else if (r_state == S_LOAD) begin
                if (w_accept) begin
                    r_tmo      <= '0;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0: r_asm[23:16] <= bus.byte_in;
                        2'd1: r_asm[15:8]  <= bus.byte_in;
                        2'd2: r_asm[7:0]   <= bus.byte_in;
                        default: begin
                            r_wdata <= {r_asm, bus.byte_in};
                            r_we    <= 1'b1;
                            r_acc   <= r_acc + LW'(1);
                            if ((r_acc + LW'(1)) == r_len) begin
                                r_byte_ready <= 1'b0;
                            end
                        end
                    endcase
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
                // Address advances at the end of the write cycle it was used in
                if (r_we) begin
                    r_waddr <= r_waddr + ADDR_WIDTH'(1);
                    r_words <= r_words + LW'(1);
                end
                if (w_next_state != S_LOAD) begin
                    r_byte_ready <= 1'b0;
                end
            end
        end
    end

    assign w_busy           = (r_state == S_LOAD);
    assign bus.busy         = w_busy;
    assign bus.cpu_run      = (r_state == S_DONE);
    assign bus.error        = (r_state == S_ERR);
    assign bus.byte_ready   = r_byte_ready;
    assign bus.mem_we       = r_we;
    assign bus.mem_wdata    = r_wdata;
    assign bus.words_loaded = r_words;
    // Fetch path gets the address port back combinationally once the load ends
    assign bus.mem_addr     = w_busy ? r_waddr : bus.cpu_addr;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle vector table plus multi-cycle load,
// timeout and reset-recovery sequences.
module tb_imem_loader;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    imem_loader_if #(.ADDR_WIDTH(6)) bus ();

    imem_loader #(
        .ADDR_WIDTH(6),
        .DEPTH     (64),
        .TIMEOUT   (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [6:0]  len;
        logic        bv;
        logic [7:0]  bin;
        logic [5:0]  caddr;
        logic        rdy;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        run;
        logic        busy;
        logic        err;
        logic [6:0]  wl;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic rst, input logic start, input logic [6:0] len,
                                input logic bv, input logic [7:0] bin, input logic [5:0] caddr,
                                input logic rdy, input logic we, input logic [5:0] addr,
                                input logic [31:0] wdata, input logic run, input logic busy,
                                input logic err, input logic [6:0] wl);
        vec_t v;
        v.rst = rst; v.start = start; v.len = len; v.bv = bv; v.bin = bin; v.caddr = caddr;
        v.rdy = rdy; v.we = we; v.addr = addr; v.wdata = wdata; v.run = run; v.busy = busy;
        v.err = err; v.wl = wl;
        return v;
    endfunction

    function automatic logic [7:0] pb(input int i, input int seed);
        return 8'((i * 7 + seed) & 255);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic rdy, input logic we,
                               input logic [5:0] addr, input logic [31:0] wdata,
                               input logic run, input logic busy, input logic err,
                               input logic [6:0] wl);
        chk({tag, ".byte_ready"},   32'(bus.byte_ready),   32'(rdy));
        chk({tag, ".mem_we"},       32'(bus.mem_we),       32'(we));
        chk({tag, ".mem_addr"},     32'(bus.mem_addr),     32'(addr));
        chk({tag, ".mem_wdata"},    bus.mem_wdata,         wdata);
        chk({tag, ".cpu_run"},      32'(bus.cpu_run),      32'(run));
        chk({tag, ".busy"},         32'(bus.busy),         32'(busy));
        chk({tag, ".error"},        32'(bus.error),        32'(err));
        chk({tag, ".words_loaded"}, 32'(bus.words_loaded), 32'(wl));
    endtask

    // Full load: start, stream 4*n bytes, score every write, bound the wait on cpu_run
    task automatic load_stream(input int n, input bit thr, input int seed);
        int          sent;
        int          nw;
        int          cyc;
        logic [31:0] w;
        @(negedge clk);
        bus.start = 1'b1; bus.len = 7'(n); bus.byte_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        sent = 0; nw = 0; cyc = 0;
        while (bus.cpu_run !== 1'b1 && cyc < 3000) begin
            bus.byte_valid = (!thr || (cyc % 2 == 0)) && (sent < 4 * n);
            bus.byte_in    = pb(sent, seed);
            #1;
            if (bus.mem_we === 1'b1) begin
                w = {pb(4 * nw, seed), pb(4 * nw + 1, seed), pb(4 * nw + 2, seed), pb(4 * nw + 3, seed)};
                chk("load.mem_addr", 32'(bus.mem_addr), 32'(nw));
                chk("load.mem_wdata", bus.mem_wdata, w);
                nw++;
            end
            if (sent == 4 * n) chk("load.byte_ready_after_last", 32'(bus.byte_ready), 32'd0);
            if (bus.byte_valid && bus.byte_ready) sent++;
            cyc++;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        #1;
        chk("load.cpu_run", 32'(bus.cpu_run), 32'd1);
        chk("load.busy", 32'(bus.busy), 32'd0);
        chk("load.writes", 32'(nw), 32'(n));
        chk("load.bytes", 32'(sent), 32'(4 * n));
        chk("load.words_loaded", 32'(bus.words_loaded), 32'(n));
        if (!thr) chk("load.latency", 32'(cyc), 32'(4 * n + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;
        bus.cpu_addr = 6'h15;

        //            rst st len bv bin     ca     rdy we addr   wdata         run bsy err wl
        vecs[0]  = mk(0, 0, 0,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1,  1, 8'hAA, 6'h15, 0, 0, 6'h15, 32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,  1, 8'h20, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0,  1, 8'h08, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0,  1, 8'h00, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0,  1, 8'h05, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0,  0, 8'h00, 6'h15, 0, 1, 6'h00, 32'h20080005, 0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h20080005, 1, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0,  0, 8'h00, 6'h2A, 0, 0, 6'h2A, 32'h20080005, 1, 0, 0, 1);
        vecs[9]  = mk(1, 0, 0,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h20080005, 1, 0, 0, 1);
        vecs[10] = mk(0, 1, 0,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h0,        0, 0, 0, 0);
        vecs[11] = mk(0, 1, 65, 0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h0,        0, 0, 1, 0);
        vecs[12] = mk(0, 0, 0,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h0,        0, 0, 1, 0);
        vecs[13] = mk(0, 1, 2,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h0,        0, 0, 1, 0);
        vecs[14] = mk(0, 0, 0,  1, 8'h11, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[15] = mk(0, 0, 0,  1, 8'h22, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[16] = mk(0, 0, 0,  1, 8'h33, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[17] = mk(0, 1, 1,  1, 8'h44, 6'h15, 1, 0, 6'h00, 32'h0,        0, 1, 0, 0);
        vecs[18] = mk(0, 0, 0,  1, 8'h55, 6'h15, 1, 1, 6'h00, 32'h11223344, 0, 1, 0, 0);
        vecs[19] = mk(0, 0, 0,  1, 8'h66, 6'h15, 1, 0, 6'h01, 32'h11223344, 0, 1, 0, 1);
        vecs[20] = mk(0, 0, 0,  1, 8'h77, 6'h15, 1, 0, 6'h01, 32'h11223344, 0, 1, 0, 1);
        vecs[21] = mk(0, 0, 0,  1, 8'h88, 6'h15, 1, 0, 6'h01, 32'h11223344, 0, 1, 0, 1);
        vecs[22] = mk(0, 0, 0,  1, 8'h99, 6'h15, 0, 1, 6'h01, 32'h55667788, 0, 1, 0, 1);
        vecs[23] = mk(0, 0, 0,  0, 8'h00, 6'h15, 0, 0, 6'h15, 32'h55667788, 1, 0, 0, 2);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; bus.start = vecs[i].start; bus.len = vecs[i].len;
            bus.byte_valid = vecs[i].bv; bus.byte_in = vecs[i].bin; bus.cpu_addr = vecs[i].caddr;
            #1;
            chk_outputs($sformatf("v%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                        vecs[i].run, vecs[i].busy, vecs[i].err, vecs[i].wl);
        end

        // Full 64-word load with byte_valid toggling
        load_stream(64, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("full.no_extra_write", 32'(bus.mem_we), 32'd0);
        end

        // Timeout: 3 bytes of a 2-word load, then silence
        @(negedge clk);
        bus.start = 1'b1; bus.len = 7'd2; bus.byte_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.byte_valid = 1'b1; bus.byte_in = pb(k, 1);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        for (int m = 0; m <= 16; m++) begin
            #1;
            chk($sformatf("tmo.error_m%0d", m), 32'(bus.error), 32'(m == 16));
            chk("tmo.no_write", 32'(bus.mem_we), 32'd0);
            if (m == 16) begin
                chk("tmo.cpu_run", 32'(bus.cpu_run), 32'd0);
                chk("tmo.byte_ready", 32'(bus.byte_ready), 32'd0);
            end
            @(negedge clk);
        end

        // Reset after 6 bytes of a 4-word load
        bus.start = 1'b1; bus.len = 7'd4;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.byte_valid = 1'b1; bus.byte_in = pb(k, 5);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outputs("rst_mid", 1'b0, 1'b0, 6'h15, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0);

        // Fresh load from word 0 after the interrupted one
        load_stream(4, 1'b0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
